// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter in front of the HD44780 write_cycle engine.
// It serialises byte writes, applies the post-write execution delay and acknowledges each byte.
module lcd_bus_arbiter #(
  parameter int unsigned SHORT_DLY  = 4,
  parameter int unsigned LONG_DLY   = 80,
  parameter int unsigned WR_TIMEOUT = 32,
  parameter int unsigned CW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       wr_finish,
  output logic       wr_enable,
  output logic       reg_sel,
  output logic [7:0] db_out,
  output logic       busy,
  output logic       grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DONE} state_t;

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_DLY);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_DLY);
  localparam logic [CW-1:0] TO_LAST = CW'(WR_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last, last_nx;
  logic          grant_nx;
  logic          rs_nx;
  logic [7:0]    db_nx;
  logic          terr_nx;
  logic          pick;
  logic          is_long;

  // Clear (0x01) and home (0x02/0x03) commands need the long execution delay.
  assign is_long = !reg_sel && (db_out[7:2] == '0) && (db_out[1:0] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      grant       <= 1'b0;
      reg_sel     <= 1'b0;
      db_out      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last        <= last_nx;
      grant       <= grant_nx;
      reg_sel     <= rs_nx;
      db_out      <= db_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    grant_nx = grant;
    rs_nx    = reg_sel;
    db_nx    = db_out;
    terr_nx  = timeout_err;
    pick     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          pick     = (req0 && req1) ? ~last : req1;
          state_nx = WRITE;
          cnt_nx   = '0;
          last_nx  = pick;
          grant_nx = pick;
          rs_nx    = pick ? rs1 : rs0;
          db_nx    = pick ? data1 : data0;
        end
      end
      WRITE: begin
        if (wr_finish) begin
          state_nx = HOLD;
          cnt_nx   = is_long ? LONG_C : SHORT_C;
        end else if (cnt == TO_LAST) begin
          state_nx = DONE;
          terr_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + ONE_C;
        end
      end
      HOLD: begin
        cnt_nx = cnt - ONE_C;
        if (cnt == ONE_C) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_enable = (state == WRITE);
    busy      = (state != IDLE);
    ack0      = (state == DONE) && !grant;
    ack1      = (state == DONE) && grant;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: a timeline model of each transaction checked every cycle,
// plus directed scenarios with hand-computed cycle counts and byte values.
module tb_lcd_bus_arbiter;
  localparam int unsigned SHORT_DLY  = 4;
  localparam int unsigned LONG_DLY   = 20;
  localparam int unsigned WR_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       wr_finish;
  logic       ack0, ack1, wr_enable, reg_sel, busy, grant, timeout_err;
  logic [7:0] db_out;

  int checks = 0;
  int failures = 0;
  int fin_lat = 3;

  lcd_bus_arbiter #(
    .SHORT_DLY(SHORT_DLY),
    .LONG_DLY(LONG_DLY),
    .WR_TIMEOUT(WR_TIMEOUT),
    .CW(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .wr_finish(wr_finish), .wr_enable(wr_enable),
    .reg_sel(reg_sel), .db_out(db_out),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each transaction is described by its grant edge, the edge where the
  // write phase ends, and the edge of the acknowledge cycle.
  int         cyc;
  int         m_t0, m_tf, m_td;
  logic       m_active, m_last, m_grant, m_rs, m_terr;
  logic [7:0] m_db;
  logic       m_pick;
  int         m_delay;

  assign m_pick  = (req0 && req1) ? ~m_last : req1;
  assign m_delay = (!m_rs && m_db >= 8'h01 && m_db <= 8'h03) ? int'(LONG_DLY) : int'(SHORT_DLY);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; m_active <= 1'b0; m_last <= 1'b1; m_grant <= 1'b0;
      m_rs <= 1'b0; m_db <= 8'h00; m_terr <= 1'b0;
      m_t0 <= 0; m_tf <= -1; m_td <= -100;
    end else begin
      cyc <= cyc + 1;
      if (!m_active) begin
        if (req0 || req1) begin
          m_active <= 1'b1;
          m_grant  <= m_pick;
          m_last   <= m_pick;
          m_rs     <= m_pick ? rs1 : rs0;
          m_db     <= m_pick ? data1 : data0;
          m_t0     <= cyc;
          m_tf     <= -1;
          m_td     <= -100;
        end
      end else if (m_tf < 0) begin
        if (wr_finish) begin
          m_tf <= cyc;
          m_td <= cyc + m_delay;
        end else if (cyc - m_t0 == int'(WR_TIMEOUT)) begin
          m_tf   <= cyc;
          m_td   <= cyc;
          m_terr <= 1'b1;
        end
      end else if (cyc == m_td + 1) begin
        m_active <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_active);
      check("wr_enable", wr_enable, m_active && m_tf < 0);
      check("ack0", ack0, m_active && m_tf >= 0 && (cyc - 1) == m_td && !m_grant);
      check("ack1", ack1, m_active && m_tf >= 0 && (cyc - 1) == m_td && m_grant);
      check("reg_sel", reg_sel, m_rs);
      check("db_out", db_out, m_db);
      check("timeout_err", timeout_err, m_terr);
      if (m_active) check("grant", grant, m_grant);
    end
  end

  // write_cycle stand-in: finishes fin_lat cycles after wr_enable rises (never if negative).
  initial begin
    int wr_cnt;
    wr_cnt = 0;
    wr_finish = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !wr_enable || fin_lat < 0) begin
        wr_cnt = 0;
        wr_finish = 1'b0;
      end else begin
        wr_cnt++;
        wr_finish = (wr_cnt == fin_lat);
      end
    end
  end

  task automatic run_req(input int who, input logic rs, input logic [7:0] d, input int lat,
                         input bit drop, output int wen_n, output int hold_n, output bit got);
    fin_lat = lat;
    if (who == 0) begin req0 = 1'b1; rs0 = rs; data0 = d; end
    else begin req1 = 1'b1; rs1 = rs; data1 = d; end
    wen_n = 0; hold_n = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (wr_enable) wen_n++;
      else if (busy && !ack0 && !ack1) hold_n++;
      if ((who == 0 && ack0) || (who == 1 && ack1)) got = 1'b1;
      if (drop && wen_n == 2) begin
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL ack_wait: got no ack expected ack from requester %0d", who);
    end
  endtask

  logic [7:0] ld_data [6] = '{8'h01, 8'h03, 8'h80, 8'h01, 8'h02, 8'h04};
  logic       ld_rs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int         ld_hold [6] = '{20, 20, 4, 4, 20, 4};
  logic [7:0] arb_db  [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    int wen, hold, n;
    bit ok;
    #1;
    check("rst_wr_enable", wr_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_db_out", db_out, 8'h00);
    check("rst_reg_sel", reg_sel, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_req(0, 1'b1, 8'h41, 3, 1'b0, wen, hold, ok);
    check("data_wen_cycles", wen, 3);
    check("data_hold_cycles", hold, 4);
    check("data_db_out", db_out, 8'h41);
    check("data_reg_sel", reg_sel, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_req(0, ld_rs[i], ld_data[i], 2, 1'b0, wen, hold, ok);
      check("delay_hold_cycles", hold, ld_hold[i]);
    end

    // Both requesters held continuously from reset release.
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h22;
    fin_lat = 2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      check("arb_ack_overlap", ack0 && ack1, 1'b0);
      if (ack0 || ack1) begin
        check("arb_grant", grant, n % 2);
        check("arb_ack_owner", {ack1, ack0}, (n % 2 == 0) ? 2'b01 : 2'b10);
        check("arb_db_out", db_out, arb_db[n]);
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("arb_ack_count", n, 4);
    repeat (2) @(negedge clk);

    run_req(0, 1'b1, 8'h55, -1, 1'b0, wen, hold, ok);
    check("to_wen_cycles", wen, WR_TIMEOUT);
    check("to_hold_cycles", hold, 0);
    check("to_err_set", timeout_err, 1'b1);
    run_req(1, 1'b1, 8'h66, 2, 1'b0, wen, hold, ok);
    check("to_next_wen", wen, 2);
    check("to_next_hold", hold, 4);
    check("to_err_sticky", timeout_err, 1'b1);

    run_req(1, 1'b1, 8'h77, 4, 1'b1, wen, hold, ok);
    check("wd_wen_cycles", wen, 4);
    check("wd_ack", ok, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || ack1) n++;
    end
    check("wd_no_regrant", n, 0);
    check("wd_db_out", db_out, 8'h77);

    // Asynchronous reset in the middle of a write.
    fin_lat = -1;
    req0 = 1'b1; rs0 = 1'b0; data0 = 8'h99;
    repeat (2) @(negedge clk);
    check("mid_wr_enable", wr_enable, 1'b1);
    #2 rst = 1'b1;
    req0 = 1'b0;
    #1;
    check("mid_rst_wr_enable", wr_enable, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_acks", {ack0, ack1}, 2'b00);
    check("mid_rst_db_out", db_out, 8'h00);
    check("mid_rst_timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fin_lat = 2;
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h38;
    @(negedge clk);
    check("post_rst_wr_enable", wr_enable, 1'b1);
    check("post_rst_grant", grant, 1'b1);
    check("post_rst_db_out", db_out, 8'h38);
    n = 0;
    for (int i = 0; i < 50 && n == 0; i++) begin
      @(negedge clk);
      if (ack1) n = 1;
    end
    req1 = 1'b0;
    check("post_rst_ack1", n, 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780 write path (write_cycle engine plus DB bus) between two byte-level requesters: requester 0 is the init/refresh sequencer, requester 1 is the keypad echo/status writer.
- Serialises the requests, drives the wr_enable/wr_finish handshake and presents reg_sel/db_out.
- Enforces the LCD post-write execution delay: long for clear/home, short otherwise.
- Acknowledges each requester when its byte has been fully committed. Runs in the slow_clk domain.

Parameters:
- SHORT_DLY, 4: hold cycles after a normal command/data write; must be ≥1.
- LONG_DLY, 80: hold cycles after a clear (0x01) or home (0x02/0x03) command; must be ≥1.
- WR_TIMEOUT, 32: max cycles waiting for wr_finish before abort; must be ≥2.
- CW, 8: width of the delay/timeout counter; must hold max(LONG_DLY, WR_TIMEOUT).

Ports:
- clk  in  1  clock (slow_clk domain)
- rst  in  1  asynchronous reset, active-high
- req0  in  1  requester 0 request level
- rs0  in  1  requester 0 register select (0 = command, 1 = data)
- data0  in  8  requester 0 byte
- ack0  out  1  one-cycle completion pulse to requester 0
- req1  in  1  requester 1 request level
- rs1  in  1  requester 1 register select
- data1  in  8  requester 1 byte
- ack1  out  1  one-cycle completion pulse to requester 1
- wr_finish  in  1  write_cycle done indication
- wr_enable  out  1  start/hold request to write_cycle
- reg_sel  out  1  registered RS for the granted byte
- db_out  out  8  registered byte for the LCD datapath
- busy  out  1  high in any state other than IDLE
- grant  out  1  index of the requester currently served (valid while busy)
- timeout_err  out  1  sticky; set on wr_finish timeout, cleared only by rst

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state = IDLE; wr_enable, reg_sel, ack0, ack1, busy, timeout_err = 0; db_out = 0x00; grant = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Counter = 0.
- States: IDLE, WRITE, HOLD, DONE.
- IDLE:
  - If only one reqN is high, grant that requester.
  - If both are high, grant the one not equal to last.
  - On the granting edge: latch rsN → reg_sel, dataN → db_out, grant = N, last = N; set wr_enable = 1; counter = 0; go to WRITE.
  - wr_enable is therefore high in the first cycle after the edge on which req was sampled high.
- WRITE:
  - wr_enable stays high; reg_sel/db_out stay stable. Counter increments each cycle.
  - If wr_finish is sampled high: wr_enable = 0; counter loaded with the delay value; go to HOLD.
    - Delay value is LONG_DLY when reg_sel = 0 and db_out[7:2] = 0 and db_out[1:0] ≠ 0; otherwise SHORT_DLY.
  - Else if counter reaches WR_TIMEOUT−1: wr_enable = 0; timeout_err = 1; go to DONE (HOLD skipped).
  - wr_finish takes priority over timeout on the same edge.
- HOLD:
  - Counter decrements each cycle. At counter = 1, go to DONE.
  - HOLD therefore lasts exactly the delay value in cycles.
  - wr_finish is ignored in HOLD.
- DONE:
  - ackN for the granted requester is high for exactly this one cycle.
  - Return to IDLE. A new grant can occur on the next IDLE cycle (no back-to-back grant from DONE).
- Request protocol:
  - Requester holds reqN, rsN and dataN stable until it sees ackN.
  - Inputs are sampled only on the grant edge.
  - Dropping reqN mid-transaction does not cancel it; ackN still pulses.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Outputs reg_sel/db_out keep their last value in IDLE. ack0 and ack1 are never high simultaneously.
- Throughput: one byte per 1 (IDLE) + write cycles + delay + 1 (DONE) cycles.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-WRITE while wr_enable = 1.
  - Response: wr_enable, busy and ack go 0 immediately (async); after release, req1 alone is granted with wr_enable high one cycle after the sampling edge.
- Single data write, SHORT_DLY = 4:
  - Stimulus: req0 with rs0 = 1, data0 = 0x41; wr_finish returned 3 cycles after wr_enable rises.
  - Response: reg_sel = 1, db_out = 0x41; wr_enable drops the cycle after wr_finish; ack0 pulses exactly 5 cycles after wr_enable falls (4 HOLD + 1 DONE).
- Long delay, LONG_DLY = 20:
  - Stimulus 1: rs0 = 0, data0 = 0x01. Response: 20 HOLD cycles before ack0.
  - Stimulus 2: data0 = 0x03. Response: 20 HOLD cycles.
  - Stimulus 3: data0 = 0x80. Response: 4 HOLD cycles.
  - Stimulus 4: rs0 = 1, data0 = 0x01. Response: 4 HOLD cycles.
- Arbitration:
  - Stimulus: req0 and req1 held high continuously from reset release with distinct bytes (0x11, 0x22).
  - Response: grant sequence 0,1,0,1; db_out alternates 0x11/0x22; acks alternate and never overlap.
- Timeout, WR_TIMEOUT = 8:
  - Stimulus: wr_finish never asserted.
  - Response: wr_enable high for exactly 8 cycles; timeout_err = 1 and stays 1; ackN pulses; the next request is still served normally.
- Request withdrawal:
  - Stimulus: req1 dropped 2 cycles into WRITE.
  - Response: the transfer completes with the latched byte; ack1 still pulses once; no further grant to requester 1.
